sb_packet_decoder: RTL and testbench
====================================

// Module: sb_packet_decoder
// PURPOSE
// - Sideband receive-side decoder: consumes 64-bit words from the SB deserializer, detects the
//   clock-pattern during sideband init, then frames header / optional data phases into messages.
// - Sits between the SB deserializer and the SB message/LTSM logic; mirror of the TX encoder path.
// - Reports pattern-sampling done, pattern timeout, and completed messages.
// PARAMETERS
// - PATTERN_WORD   64'hAAAA_AAAA_AAAA_AAAA  value of one sideband pattern word
// - PATTERN_CNT    4                        consecutive pattern words for "sampled" (2 x 128b iterations)
// - TIMEOUT_CYCLES 800000                   search cycles before timeout (8 ms @ 100 MHz)
// PORTS
// - i_clk                   in   1   sideband clock
// - i_rst                   in   1   synchronous reset, active-high
// - i_pattern_detect_en     in   1   level; start/keep pattern search (from LTSM SB init)
// - i_deser_valid           in   1   one-cycle strobe: i_deser_data holds a new word
// - i_deser_data            in   64  deserialized word
// - o_rx_sb_pattern_samp_done out 1  one-cycle pulse: pattern sampled
// - o_pattern_time_out      out  1   sticky; no pattern within TIMEOUT_CYCLES
// - o_msg_valid             out  1   one-cycle pulse: o_header/o_data/o_has_data valid
// - o_header                out  64  received header word
// - o_data                  out  64  received data word (0 when o_has_data=0)
// - o_has_data              out  1   message carried a data phase
// - o_parity_err            out  1   one-cycle pulse: cp/dp mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0. Reset mid-message discards the partial message.
// - FSM: IDLE, PAT_SEARCH, HEADER, DATA.
//   IDLE -> PAT_SEARCH on i_pattern_detect_en=1.
//   PAT_SEARCH: timeout ctr +1 per cycle; pattern ctr +1 per valid word == PATTERN_WORD,
//     cleared to 0 on valid non-pattern word. Valid pattern word making ctr == PATTERN_CNT:
//     pulse samp_done next cycle, -> HEADER. Timeout ctr reaching TIMEOUT_CYCLES-1 without done:
//     set o_pattern_time_out, -> IDLE. Simultaneous timeout and final pattern word: done wins.
//   i_pattern_detect_en falling in PAT_SEARCH: -> IDLE, counters cleared, no pulses.
//   HEADER: valid word == PATTERN_WORD ignored (partner still sending pattern). Other valid word
//     latched as header; opcode = hdr[4:0]; data-bearing opcodes 5'b00001, 5'b00101, 5'b01001,
//     5'b11011 -> DATA; else message complete, stay HEADER.
//   DATA: next valid word latched as data (pattern value NOT filtered here), message complete,
//     -> HEADER.
// - Message complete: o_msg_valid pulses the cycle after the final word's i_deser_valid; o_header,
//   o_data, o_has_data update same cycle and hold until next message.
// - Back-to-back strobes every cycle supported; no backpressure, no words dropped.
// - o_pattern_time_out cleared only by reset or a new IDLE -> PAT_SEARCH entry.
// - Parity: cp = hdr[63], even parity over hdr[61:0]; dp = hdr[62], even parity over data[63:0].
// CONFIGURATION
// - SB_RX_PARITY_CHECK_EN defined: cp checked on header, dp checked on data; mismatch pulses
//   o_parity_err in the completion cycle and suppresses o_msg_valid (message dropped, FSM
//   continues normally).
// - Not defined: no parity logic; o_parity_err tied 0; every framed message delivered.
// TESTING
// - en=1, 4 valid 64'hAAAA.. words -> samp_done one cycle after 4th; state HEADER.
// - 3 pattern words, 1 64'h0, 4 pattern words -> single samp_done after 8th word only.
// - TIMEOUT_CYCLES=100, en=1, no pattern -> o_pattern_time_out=1 at cycle 100, state IDLE.
// - After sampling: 2 pattern words then header opcode 5'b11011 + data 64'h1234 -> one
//   o_msg_valid, o_has_data=1, o_data=64'h1234; opcode 5'b10010 header -> o_has_data=0, o_data=0.
// - SB_RX_PARITY_CHECK_EN: header with flipped cp -> o_parity_err pulse, no o_msg_valid; next
//   good header delivered. Without macro: same stimulus -> o_msg_valid, o_parity_err=0.
// - i_rst asserted between header and data of a data message -> no o_msg_valid, outputs 0.

Source files
------------

// File: rtl/sb_packet_decoder.sv
// Sideband RX decoder: finds the clock pattern during SB init, then frames header/data words into messages.
// Optional SB_RX_PARITY_CHECK_EN enables cp/dp checking; messages with a parity mismatch are dropped.
module sb_packet_decoder #(
    parameter logic [63:0] PATTERN_WORD   = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter int unsigned PATTERN_CNT    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pattern_detect_en,
    input  logic        i_deser_valid,
    input  logic [63:0] i_deser_data,
    output logic        o_rx_sb_pattern_samp_done,
    output logic        o_pattern_time_out,
    output logic        o_msg_valid,
    output logic [63:0] o_header,
    output logic [63:0] o_data,
    output logic        o_has_data,
    output logic        o_parity_err
);

    localparam int unsigned PAT_W = $clog2(PATTERN_CNT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PAT_SEARCH = 2'd1,
        HEADER     = 2'd2,
        DATA       = 2'd3
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [63:0]        hdr_q;

    logic               is_pattern;
    logic               has_data_op;
    logic               msg_done;
    logic [63:0]        msg_hdr;
    logic [63:0]        msg_data;
    logic               msg_perr;

    // Word classification and message-completion decode for the current strobe.
    always_comb begin
        is_pattern  = (i_deser_data == PATTERN_WORD);
        has_data_op = (i_deser_data[4:0] == 5'b00001) || (i_deser_data[4:0] == 5'b00101) ||
                      (i_deser_data[4:0] == 5'b01001) || (i_deser_data[4:0] == 5'b11011);
        msg_done    = 1'b0;
        msg_hdr     = i_deser_data;
        msg_data    = 64'd0;
        if (i_deser_valid) begin
            if (state == HEADER) begin
                msg_done = !is_pattern && !has_data_op;
            end else if (state == DATA) begin
                msg_done = 1'b1;
                msg_hdr  = hdr_q;
                msg_data = i_deser_data;
            end
        end
    end

`ifdef SB_RX_PARITY_CHECK_EN
    logic hdr_perr;
    logic cp_bad;
    logic dp_bad;

    // cp covers header bits [61:0], dp covers the data word; both are even parity.
    always_comb begin
        cp_bad   = (i_deser_data[63] != (^i_deser_data[61:0]));
        dp_bad   = (hdr_q[62] != (^i_deser_data));
        msg_perr = (state == DATA) ? (hdr_perr || dp_bad) : cp_bad;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hdr_perr     <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= msg_done && msg_perr;
            if (state == HEADER && i_deser_valid && !is_pattern && has_data_op) begin
                hdr_perr <= cp_bad;
            end
        end
    end
`else
    assign msg_perr     = 1'b0;
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                     <= IDLE;
            pat_cnt                   <= '0;
            tmo_cnt                   <= '0;
            hdr_q                     <= 64'd0;
            o_rx_sb_pattern_samp_done <= 1'b0;
            o_pattern_time_out        <= 1'b0;
            o_msg_valid               <= 1'b0;
            o_header                  <= 64'd0;
            o_data                    <= 64'd0;
            o_has_data                <= 1'b0;
        end else begin
            o_rx_sb_pattern_samp_done <= 1'b0;
            o_msg_valid               <= 1'b0;

            // Dropped (parity-failed) messages leave the previous message on the outputs.
            if (msg_done && !msg_perr) begin
                o_msg_valid <= 1'b1;
                o_header    <= msg_hdr;
                o_data      <= msg_data;
                o_has_data  <= (state == DATA);
            end

            case (state)
                IDLE: begin
                    if (i_pattern_detect_en) begin
                        state              <= PAT_SEARCH;
                        pat_cnt            <= '0;
                        tmo_cnt            <= '0;
                        o_pattern_time_out <= 1'b0;
                    end
                end
                PAT_SEARCH: begin
                    // Losing enable aborts silently; a completing pattern word beats the timeout.
                    if (!i_pattern_detect_en) begin
                        state   <= IDLE;
                        pat_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (i_deser_valid && is_pattern &&
                                 pat_cnt == PAT_W'(PATTERN_CNT - 1)) begin
                        state                     <= HEADER;
                        pat_cnt                   <= '0;
                        tmo_cnt                   <= '0;
                        o_rx_sb_pattern_samp_done <= 1'b1;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state              <= IDLE;
                        pat_cnt            <= '0;
                        tmo_cnt            <= '0;
                        o_pattern_time_out <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (i_deser_valid) begin
                            pat_cnt <= is_pattern ? pat_cnt + 1'b1 : '0;
                        end
                    end
                end
                HEADER: begin
                    if (i_deser_valid && !is_pattern) begin
                        hdr_q <= i_deser_data;
                        if (has_data_op) begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (i_deser_valid) begin
                        state <= HEADER;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_packet_decoder.sv
// Scoreboard bench for sb_packet_decoder: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_sb_packet_decoder;

    localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int K_SAMP = 0;
    localparam int K_MSG  = 1;
    localparam int K_PERR = 2;
    localparam int K_TMO  = 3;
    localparam int K_IDLE = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] hdr;
        logic [63:0] data;
        logic        has;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        v;
    logic [63:0] d;
    logic        samp_done;
    logic        time_out;
    logic        msg_valid;
    logic [63:0] header;
    logic [63:0] data;
    logic        has_data;
    logic        parity_err;

    exp_t q[$];
    int   cyc;
    int   vec;
    int   err;
    bit   done;

    sb_packet_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_pattern_detect_en       (en),
        .i_deser_valid             (v),
        .i_deser_data              (d),
        .o_rx_sb_pattern_samp_done (samp_done),
        .o_pattern_time_out        (time_out),
        .o_msg_valid               (msg_valid),
        .o_header                  (header),
        .o_data                    (data),
        .o_has_data                (has_data),
        .o_parity_err              (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input int kind, input logic [63:0] h,
                                 input logic [63:0] dd, input logic hs, input logic t);
        exp_t e;
        e.cyc = c; e.kind = kind; e.hdr = h; e.data = dd; e.has = hs; e.tmo = t;
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [63:0] w);
        tick();
        v = 1'b1;
        d = w;
    endtask

    task automatic gap();
        tick();
        v = 1'b0;
        d = 64'd0;
    endtask

    task automatic do_reset();
        tick();
        v   = 1'b0;
        en  = 1'b0;
        rst = 1'b1;
        push(cyc + 1, K_IDLE, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    // Stimulus: directed vectors; signals set after edge N are sampled at N+1 and seen at cyc N+1.
    initial begin
        int k;
        rst = 1'b1; en = 1'b0; v = 1'b0; d = 64'd0; done = 1'b0;
        tick();
        tick();
        push(cyc + 1, K_IDLE, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // Timeout with no pattern, then sticky hold, then cleared on re-entry.
        tick();
        en = 1'b1;
        k  = cyc;
        push(k + 100, K_TMO, 0, 0, 0, 1'b0);
        push(k + 101, K_TMO, 0, 0, 0, 1'b1);
        push(k + 105, K_TMO, 0, 0, 0, 1'b1);
        repeat (101) tick();
        en = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        push(cyc + 1, K_TMO, 0, 0, 0, 1'b0);
        tick();
        en = 1'b0;

        // Four pattern words (with a gap) -> sampled; then message framing.
        do_reset();
        en = 1'b1;
        word(PAT); word(PAT); gap(); word(PAT);
        word(PAT); push(cyc + 1, K_SAMP, 0, 0, 0, 0);
        gap();
        word(PAT); word(PAT);
        word(64'h4000_0000_0000_001B);
        word(64'h0000_0000_0000_1234);
        push(cyc + 1, K_MSG, 64'h4000_0000_0000_001B, 64'h0000_0000_0000_1234, 1'b1, 0);
        word(64'h0000_0000_0000_0012);
        push(cyc + 1, K_MSG, 64'h0000_0000_0000_0012, 64'd0, 1'b0, 0);
        word(64'h8000_0000_ABCD_0001);
        word(64'hFFFF_FFFF_FFFF_FFFF);
        push(cyc + 1, K_MSG, 64'h8000_0000_ABCD_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        word(64'h0000_0000_0000_0005);
        word(PAT);
        push(cyc + 1, K_MSG, 64'h0000_0000_0000_0005, PAT, 1'b1, 0);
        gap();
        word(64'h8000_0000_0000_0012);
`ifdef SB_RX_PARITY_CHECK_EN
        push(cyc + 1, K_PERR, 0, 0, 0, 0);
`else
        push(cyc + 1, K_MSG, 64'h8000_0000_0000_0012, 64'd0, 1'b0, 0);
`endif
        word(64'h0000_0000_0000_0003);
        push(cyc + 1, K_MSG, 64'h0000_0000_0000_0003, 64'd0, 1'b0, 0);
        word(64'h0000_0000_0000_001B);
        word(64'h0000_0000_0000_1234);
`ifdef SB_RX_PARITY_CHECK_EN
        push(cyc + 1, K_PERR, 0, 0, 0, 0);
`else
        push(cyc + 1, K_MSG, 64'h0000_0000_0000_001B, 64'h0000_0000_0000_1234, 1'b1, 0);
`endif
        gap();

        // Reset between header and data discards the message.
        word(64'h4000_0000_0000_001B);
        do_reset();
        word(64'h0000_0000_0000_1234);
        gap();

        // Non-pattern word restarts the run: sampled only after the 8th word.
        do_reset();
        en = 1'b1;
        word(PAT); word(PAT); word(PAT); word(64'd0);
        word(PAT); word(PAT); word(PAT);
        word(PAT); push(cyc + 1, K_SAMP, 0, 0, 0, 0);
        gap();

        // Dropping enable mid-search clears the pattern count.
        do_reset();
        en = 1'b1;
        word(PAT); word(PAT);
        gap(); en = 1'b0;
        tick(); en = 1'b1;
        gap();
        word(PAT); word(PAT); word(PAT);
        word(PAT); push(cyc + 1, K_SAMP, 0, 0, 0, 0);
        gap();
        repeat (3) tick();
        done = 1'b1;
    end

    // Monitor: pops expectations due this cycle and flags any unexpected pulse.
    always @(negedge clk) begin
        exp_t e;
        exp_t m;
        logic e_samp;
        logic e_msg;
        logic e_perr;
        e_samp = 1'b0; e_msg = 1'b0; e_perr = 1'b0;
        m = '{0, 0, 64'd0, 64'd0, 1'b0, 1'b0};
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                vec++; err++;
                $display("FAIL stale_expect kind=%0d due=%0d now=%0d", e.kind, e.cyc, cyc);
            end else begin
                case (e.kind)
                    K_SAMP: e_samp = 1'b1;
                    K_PERR: e_perr = 1'b1;
                    K_MSG: begin e_msg = 1'b1; m = e; end
                    K_TMO: begin
                        vec++;
                        if (time_out !== e.tmo) begin
                            err++;
                            $display("FAIL time_out cyc=%0d got=%b exp=%b", cyc, time_out, e.tmo);
                        end
                    end
                    default: begin
                        vec++;
                        if ({samp_done, time_out, msg_valid, header, data, has_data, parity_err} !== '0) begin
                            err++;
                            $display("FAIL reset_outputs cyc=%0d got samp=%b tmo=%b mv=%b hdr=%h data=%h has=%b perr=%b exp all 0",
                                     cyc, samp_done, time_out, msg_valid, header, data, has_data, parity_err);
                        end
                    end
                endcase
            end
        end
        if (samp_done || e_samp) begin
            vec++;
            if (samp_done !== e_samp) begin
                err++;
                $display("FAIL samp_done cyc=%0d got=%b exp=%b", cyc, samp_done, e_samp);
            end
        end
        if (msg_valid || e_msg) begin
            vec++;
            if (msg_valid !== e_msg || (e_msg && {header, data, has_data} !== {m.hdr, m.data, m.has})) begin
                err++;
                $display("FAIL msg cyc=%0d got v=%b hdr=%h data=%h has=%b exp v=%b hdr=%h data=%h has=%b",
                         cyc, msg_valid, header, data, has_data, e_msg, m.hdr, m.data, m.has);
            end
        end
        if (parity_err || e_perr) begin
            vec++;
            if (parity_err !== e_perr) begin
                err++;
                $display("FAIL parity_err cyc=%0d got=%b exp=%b", cyc, parity_err, e_perr);
            end
        end
        if (done || cyc > 3000) begin
            vec++;
            if (!done || q.size() != 0) begin
                err++;
                $display("FAIL end_of_test done=%b pending=%0d exp done=1 pending=0", done, q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vec, err);
            $finish;
        end
    end

endmodule
